// File: rtl/lvds_frame_tx.sv
// rtl/lvds_frame_tx.sv - framed byte transmitter feeding an LVDS serializer
//
// Emits frames of the form HDR0, HDR1, PAYLOAD_LEN payload bytes, then at
// least GAP_LEN idle bytes. A frame is requested by holding start high in
// IDLE; payload bytes are pulled from an upstream source with a
// valid/ready handshake. A missing payload byte is replaced by IDLE_BYTE
// so the frame length never changes, and the starvation is flagged.
//
// Ports:
//   clk           rising-edge clock for all logic
//   rst_n         asynchronous active-low reset
//   start         frame request, sampled only while idle
//   pay_data      upstream payload byte
//   pay_valid     pay_data holds a byte
//   pay_ready     a payload byte is taken on this edge (payload slots)
//   clr_underrun  synchronous clear of the underrun flag
//   tx_data       registered byte stream to the serializer
//   tx_busy       frame in progress (acceptance through gap completion)
//   frame_done    one-cycle pulse alongside the final gap byte
//   underrun      sticky payload-starvation flag
//   frame_cnt     number of completed frames, wraps at 16 bits

module lvds_frame_tx #(
    parameter int unsigned PAYLOAD_LEN = 124,
    parameter int unsigned GAP_LEN     = 4,
    parameter logic [7:0]  IDLE_BYTE   = 8'h00,
    parameter logic [7:0]  HDR0        = 8'hEE,
    parameter logic [7:0]  HDR1        = 8'h33
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  pay_data,
    input  logic        pay_valid,
    output logic        pay_ready,
    output logic [7:0]  tx_data,
    output logic        tx_busy,
    output logic        frame_done,
    output logic        underrun,
    input  logic        clr_underrun,
    output logic [15:0] frame_cnt
);

    // Each state names the byte that is loaded into tx_data on the next edge.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HDR0    = 3'd1,
        S_HDR1    = 3'd2,
        S_PAYLOAD = 3'd3,
        S_GAP     = 3'd4
    } state_t;

    localparam logic [9:0] SLOT_LAST = 10'(PAYLOAD_LEN - 1);
    localparam logic [7:0] GAP_LAST  = 8'(GAP_LEN - 1);

    state_t     state;
    logic [9:0] slot_cnt;
    logic [7:0] gap_cnt;

    // Every payload slot consumes (or skips) exactly one byte, so ready is
    // simply the state decode.
    always_comb begin
        pay_ready = (state == S_PAYLOAD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            tx_data    <= IDLE_BYTE;
            tx_busy    <= 1'b0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
            frame_cnt  <= 16'd0;
            slot_cnt   <= 10'd0;
            gap_cnt    <= 8'd0;
        end else begin
            frame_done <= 1'b0;

            // Clear has priority over a starvation event in the same cycle.
            if (clr_underrun) begin
                underrun <= 1'b0;
            end else if (pay_ready && !pay_valid) begin
                underrun <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    tx_data <= IDLE_BYTE;
                    // Busy falls here, one cycle after frame_done, unless a
                    // new frame is accepted on the same edge.
                    tx_busy <= start;
                    if (start) begin
                        state <= S_HDR0;
                    end
                end

                S_HDR0: begin
                    tx_data <= HDR0;
                    state   <= S_HDR1;
                end

                S_HDR1: begin
                    tx_data  <= HDR1;
                    slot_cnt <= 10'd0;
                    state    <= S_PAYLOAD;
                end

                S_PAYLOAD: begin
                    // A starved slot still occupies its position in the frame.
                    tx_data  <= pay_valid ? pay_data : IDLE_BYTE;
                    slot_cnt <= slot_cnt + 10'd1;
                    if (slot_cnt == SLOT_LAST) begin
                        gap_cnt <= 8'd0;
                        state   <= S_GAP;
                    end
                end

                S_GAP: begin
                    tx_data <= IDLE_BYTE;
                    if (gap_cnt == GAP_LAST) begin
                        frame_done <= 1'b1;
                        frame_cnt  <= frame_cnt + 16'd1;
                        state      <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end

                default: begin
                    tx_data <= IDLE_BYTE;
                    tx_busy <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lvds_frame_tx.sv
// tb/tb_lvds_frame_tx.sv - self-checking bench for lvds_frame_tx

module tb_lvds_frame_tx;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  pay_data;
    logic        pay_valid;
    logic        pay_ready;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic        frame_done;
    logic        underrun;
    logic        clr_underrun;
    logic [15:0] frame_cnt;

    lvds_frame_tx dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .pay_data     (pay_data),
        .pay_valid    (pay_valid),
        .pay_ready    (pay_ready),
        .tx_data      (tx_data),
        .tx_busy      (tx_busy),
        .frame_done   (frame_done),
        .underrun     (underrun),
        .clr_underrun (clr_underrun),
        .frame_cnt    (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Per-cycle capture, indexed by cycles after the start-acceptance edge.
    logic [7:0] log_data [0:511];
    logic       log_busy [0:511];
    logic       log_done [0:511];
    logic       log_ready[0:511];
    logic       log_urun [0:511];
    int         cyc;
    int         idx;

    // Header-aligning receiver model fed from tx_data.
    logic [7:0] rx_prev;
    bit         rx_locked;
    int         rx_count;
    int         rx_hdr_hits;
    int         rx_frames;

    typedef struct {
        int         off;
        logic [7:0] data;
        logic       busy;
        logic       done;
        logic       ready;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic rx_reset();
        rx_prev     = 8'h00;
        rx_locked   = 1'b0;
        rx_count    = 0;
        rx_hdr_hits = 0;
        rx_frames   = 0;
    endtask

    task automatic rx_byte(input logic [7:0] b);
        if (rx_locked) begin
            rx_count++;
            if (rx_count == 124) begin
                rx_locked = 1'b0;
                rx_frames++;
            end
        end else if (rx_prev == 8'hEE && b == 8'h33) begin
            rx_locked = 1'b1;
            rx_count  = 0;
            rx_hdr_hits++;
        end
        rx_prev = b;
    endtask

    // One clock: the source hands over a byte when ready&valid at the edge.
    task automatic step();
        bit consumed;
        consumed = pay_ready && pay_valid;
        @(posedge clk);
        #1;
        if (consumed) begin
            idx++;
            pay_data = idx[7:0];
        end
        if (cyc < 512) begin
            log_data[cyc]  = tx_data;
            log_busy[cyc]  = tx_busy;
            log_done[cyc]  = frame_done;
            log_ready[cyc] = pay_ready;
            log_urun[cyc]  = underrun;
        end
        rx_byte(tx_data);
        cyc++;
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        start        = 1'b0;
        pay_valid    = 1'b1;
        clr_underrun = 1'b0;
        idx          = 0;
        pay_data     = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        rx_reset();
    endtask

    // Accept a frame: the step taken with start high is cycle 0.
    task automatic accept();
        cyc   = 0;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        int bad;
        int dones;
        logic [15:0] cnt_before;

        vecs[0]  = '{0,   8'h00, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{1,   8'hEE, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{2,   8'h33, 1'b1, 1'b0, 1'b1};
        vecs[3]  = '{3,   8'h00, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{4,   8'h01, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{64,  8'h3D, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{125, 8'h7A, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{126, 8'h7B, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{127, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{129, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{130, 8'h00, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{131, 8'h00, 1'b0, 1'b0, 1'b0};

        // Reset state
        rst_n        = 1'b0;
        start        = 1'b0;
        pay_valid    = 1'b1;
        pay_data     = 8'h00;
        clr_underrun = 1'b0;
        idx          = 0;
        cyc          = 0;
        rx_reset();
        #3;
        check("rst_tx_data", {24'd0, tx_data}, 32'h00);
        check("rst_busy", {31'd0, tx_busy}, 32'd0);
        check("rst_done", {31'd0, frame_done}, 32'd0);
        check("rst_underrun", {31'd0, underrun}, 32'd0);
        check("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        check("rst_ready", {31'd0, pay_ready}, 32'd0);
        do_reset();

        // Single frame against the checkpoint table
        accept();
        for (int k = 1; k <= 131; k++) step();
        foreach (vecs[i]) begin
            check($sformatf("single_v%0d_data", i), {24'd0, log_data[vecs[i].off]}, {24'd0, vecs[i].data});
            check($sformatf("single_v%0d_busy", i), {31'd0, log_busy[vecs[i].off]}, {31'd0, vecs[i].busy});
            check($sformatf("single_v%0d_done", i), {31'd0, log_done[vecs[i].off]}, {31'd0, vecs[i].done});
            check($sformatf("single_v%0d_ready", i), {31'd0, log_ready[vecs[i].off]}, {31'd0, vecs[i].ready});
        end
        bad = 0;
        for (int i = 0; i < 124; i++) if (log_data[3 + i] !== 8'(i)) bad++;
        check("single_payload_bad", bad, 0);
        dones = 0;
        for (int k = 0; k <= 131; k++) if (log_done[k]) dones++;
        check("single_done_count", dones, 1);
        check("single_frame_cnt", {16'd0, frame_cnt}, 32'd1);
        check("single_underrun", {31'd0, underrun}, 32'd0);
        check("single_rx_frames", rx_frames, 1);

        // Back-to-back with start held high for three frames
        do_reset();
        cyc   = 0;
        start = 1'b1;
        for (int k = 0; k <= 393; k++) begin
            if (k == 263) start = 1'b0;
            step();
        end
        bad = 0;
        dones = 0;
        for (int f = 0; f < 3; f++) begin
            int base;
            base = 131 * f;
            if (log_data[base + 1] !== 8'hEE) bad++;
            if (log_data[base + 2] !== 8'h33) bad++;
            for (int i = 0; i < 124; i++) if (log_data[base + 3 + i] !== 8'(124 * f + i)) bad++;
            for (int g = 127; g <= 131; g++) if (log_data[base + g] !== 8'h00) bad++;
            if (log_done[base + 130] !== 1'b1) bad++;
        end
        for (int k = 0; k <= 393; k++) if (log_done[k]) dones++;
        check("b2b_frame_bad", bad, 0);
        check("b2b_done_count", dones, 3);
        check("b2b_frame_cnt", {16'd0, frame_cnt}, 32'd3);
        check("b2b_busy_end", {31'd0, log_busy[393]}, 32'd0);
        check("loop_hdr_hits", rx_hdr_hits, 3);
        check("loop_rx_frames", rx_frames, 3);

        // Underrun at payload slot 10
        do_reset();
        accept();
        for (int k = 1; k <= 131; k++) begin
            pay_valid = (k != 13);
            step();
        end
        pay_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 124; i++) begin
            logic [7:0] e;
            e = (i < 10) ? 8'(i) : (i == 10) ? 8'h00 : 8'(i - 1);
            if (log_data[3 + i] !== e) bad++;
        end
        check("urun_payload_bad", bad, 0);
        check("urun_before", {31'd0, log_urun[12]}, 32'd0);
        check("urun_set", {31'd0, log_urun[13]}, 32'd1);
        check("urun_done_pos", {31'd0, log_done[130]}, 32'd1);
        check("urun_sticky", {31'd0, underrun}, 32'd1);
        clr_underrun = 1'b1;
        step();
        clr_underrun = 1'b0;
        check("urun_cleared", {31'd0, underrun}, 32'd0);

        // Clear coinciding with a new starvation event
        accept();
        for (int k = 1; k <= 131; k++) begin
            pay_valid    = (k != 13);
            clr_underrun = (k == 13);
            step();
        end
        pay_valid    = 1'b1;
        clr_underrun = 1'b0;
        check("clr_wins_slot", {31'd0, log_urun[13]}, 32'd0);
        check("clr_wins_data", {24'd0, log_data[13]}, 32'h00);
        check("clr_wins_end", {31'd0, underrun}, 32'd0);

        // Start pulse mid-payload is ignored
        cnt_before = frame_cnt;
        accept();
        for (int k = 1; k <= 135; k++) begin
            start = (k == 53);
            step();
        end
        start = 1'b0;
        bad = 0;
        dones = 0;
        for (int k = 0; k <= 130; k++) if (log_busy[k] !== 1'b1) bad++;
        for (int k = 0; k <= 135; k++) if (log_done[k]) dones++;
        check("busy_no_drop", bad, 0);
        check("busy_done_count", dones, 1);
        check("busy_falls", {31'd0, log_busy[131]}, 32'd0);
        check("busy_no_hdr", {24'd0, log_data[132]}, 32'h00);
        check("busy_frame_cnt", {16'd0, frame_cnt}, {16'd0, cnt_before + 16'd1});

        // Reset at payload slot 60, then a clean frame
        accept();
        for (int k = 1; k <= 63; k++) step();
        rst_n = 1'b0;
        #2;
        check("midrst_tx_data", {24'd0, tx_data}, 32'h00);
        check("midrst_busy", {31'd0, tx_busy}, 32'd0);
        check("midrst_ready", {31'd0, pay_ready}, 32'd0);
        check("midrst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        do_reset();
        accept();
        for (int k = 1; k <= 131; k++) step();
        bad = 0;
        if (log_data[1] !== 8'hEE) bad++;
        if (log_data[2] !== 8'h33) bad++;
        for (int i = 0; i < 124; i++) if (log_data[3 + i] !== 8'(i)) bad++;
        check("postrst_frame_bad", bad, 0);
        check("postrst_done", {31'd0, log_done[130]}, 32'd1);
        check("postrst_frame_cnt", {16'd0, frame_cnt}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lvds_frame_tx.md
LVDS_FRAME_TX -- requirements
Module: lvds_frame_tx

Interface
REQ-001 SHALL have parameter PAYLOAD_LEN, default 124, payload bytes per frame (legal range 1..1023).
REQ-002 SHALL have parameter GAP_LEN, default 4, minimum idle bytes after each frame (legal range 1..255).
REQ-003 SHALL have parameter IDLE_BYTE, default 8'h00, byte driven when not in a frame.
REQ-004 SHALL have parameter HDR0, default 8'hEE, first header byte.
REQ-005 SHALL have parameter HDR1, default 8'h33, second header byte.
REQ-006 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-007 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port start  input  1  frame request, level-sampled.
REQ-009 SHALL have port pay_data  input  8  payload byte from the upstream source.
REQ-010 SHALL have port pay_valid  input  1  pay_data is valid.
REQ-011 SHALL have port pay_ready  output  1  a payload byte is consumed on this edge.
REQ-012 SHALL have port tx_data  output  8  registered byte stream to the LVDS serializer.
REQ-013 SHALL have port tx_busy  output  1  high from start acceptance until gap completion.
REQ-014 SHALL have port frame_done  output  1  one-cycle pulse on the final gap byte.
REQ-015 SHALL have port underrun  output  1  sticky payload-starvation flag.
REQ-016 SHALL have port clr_underrun  input  1  synchronous clear of underrun.
REQ-017 SHALL have port frame_cnt  output  16  count of completed frames.

Function
REQ-018 SHALL implement states IDLE, HDR0, HDR1, PAYLOAD and GAP; each state names the byte loaded into tx_data on the next edge.
REQ-019 SHALL, in IDLE with start=1, go to HDR0 and assert tx_busy from the next cycle; with start=0 it SHALL stay in IDLE, driving IDLE_BYTE.
REQ-020 SHALL go HDR0->HDR1->PAYLOAD unconditionally; tx_data SHALL be HDR0 one cycle after start acceptance and HDR1 two cycles after.
REQ-021 SHALL, in PAYLOAD, drive pay_ready=1 combinationally; otherwise pay_ready=0.
REQ-022 SHALL load pay_data into tx_data when pay_ready=1 and pay_valid=1.
REQ-023 SHALL, when pay_ready=1 and pay_valid=0, load IDLE_BYTE into tx_data, still count the slot, and set underrun.
REQ-024 SHALL keep a 10-bit slot counter: reset to 0 on entering PAYLOAD, increment per PAYLOAD cycle, and leave PAYLOAD after exactly PAYLOAD_LEN slots.
REQ-025 SHALL leave PAYLOAD for GAP, emitting IDLE_BYTE for GAP_LEN cycles using an 8-bit gap counter.
REQ-026 SHALL, on the last GAP cycle, pulse frame_done for one cycle, increment frame_cnt (wrapping 16'hFFFF->0), and go to IDLE.
REQ-027 SHALL make frame latency exactly 2+PAYLOAD_LEN+GAP_LEN cycles from start acceptance to return to IDLE.
REQ-028 SHALL deassert tx_busy the cycle after frame_done.
REQ-029 SHALL ignore start outside IDLE, with no queuing.
REQ-030 SHALL, when start is held high, start frames back-to-back with exactly GAP_LEN IDLE_BYTE slots plus one IDLE cycle between frames.
REQ-031 SHALL let clr_underrun win when it coincides with a new underrun event, leaving underrun at 0.

Reset
REQ-032 SHALL, on rst_n=0, immediately set state to IDLE, tx_data to IDLE_BYTE, and tx_busy, frame_done, underrun, frame_cnt and both counters to 0.
REQ-033 SHALL abort a mid-frame reset with no partial trailer; the first frame after release SHALL be complete and begin with HDR0.

Verification
REQ-034 SHALL cover single frame: start pulse, pay_valid=1 with data 0..123 -> tx_data EE, 33, 00..7B, then 4 bytes 00; frame_done at slot 130; frame_cnt=1.
REQ-035 SHALL cover back-to-back: start held high for 3 frames -> 3 well-formed frames; frame_cnt=3; every inter-frame gap 5 cycles of 00.
REQ-036 SHALL cover underrun: pay_valid=0 at payload slot 10 only -> slot 10 carries 00; frame length unchanged; underrun=1 until clr_underrun.
REQ-037 SHALL cover start while busy: start pulse at payload slot 50 -> ignored; only one frame; tx_busy never drops mid-frame.
REQ-038 SHALL cover reset mid-frame: rst_n low at payload slot 60 -> tx_data=00 and tx_busy=0 immediately; next start yields a full frame.
REQ-039 SHALL cover loopback: output into the team's header-align receiver -> its count runs 1..124 once per frame with no false header detection.
